mul_bank_scheduler: RTL and testbench
=====================================

# mul_bank_scheduler

Round-robin scheduler that shares one multiplier bank of `LANES` fixed-point multipliers between `NUM_REQ` requesters, such as the depthwise-conv, squeeze-excite scale and hard-swish units. It grants the bank in bursts and registers the granted operand vectors onto the bank inputs. It also tracks in-flight beats with a tag pipeline matched to the bank latency, so each product vector returns to its originating requester. It sits between the layer engines and the multiplier bank top.

## Interface
- `NUM_REQ`, 3 — number of requesters (2..8).
- `LANES`, 32 — multiplier lanes per beat.
- `WIDTH`, 14 — fixed-point word width (Q6.7 with default `FRAC_BITS`).
- `MUL_LAT`, 1 — bank latency in cycles, from registered operands to `mul_result` valid.
- `MAX_BURST`, 16 — maximum beats per grant.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — **asynchronous, active-low** reset.
- `req_valid`  in  `NUM_REQ`  — per-requester beat valid.
- `req_last`  in  `NUM_REQ`  — final beat of the requester's burst.
- `req_a`, `req_b`  in  `NUM_REQ*LANES*WIDTH`  — flattened operands; requester i occupies slice `[(i+1)*LANES*WIDTH-1 : i*LANES*WIDTH]`.
- `req_ready`  out  `NUM_REQ`  — per-requester accept; at most one bit high.
- `mul_a`, `mul_b`  out  `LANES*WIDTH`  — registered operands to the bank.
- `mul_result`  in  `LANES*WIDTH`  — bank product.
- `rsp_valid`  out  `NUM_REQ`  — one-hot result strobe.
- `rsp_last`  out  1  — result belongs to the final beat of a burst.
- `rsp_data`  out  `LANES*WIDTH`  — equals `mul_result` (pass-through).
- `busy`  out  1  — high when state is `GRANT` or any tag is in flight.

## Operation
- **FSM states:** `IDLE`, `GRANT`.
- **`IDLE`:**
  - If any `req_valid` is high, select the winner by round robin: search starts at `last_owner+1` and wraps modulo `NUM_REQ`.
  - Register `owner` and clear `beat_cnt`, then go to `GRANT`.
  - With no requests, stay in `IDLE`.
- **`GRANT`:**
  - `req_ready[owner]=1`; all other `req_ready` bits are 0.
  - **Accept** occurs when `req_valid[owner] & req_ready[owner]`. On accept:
    - `mul_a`/`mul_b` load the owner's slices.
    - A tag `{1, owner, last}` enters the tag pipe.
    - `beat_cnt` increments.
  - `last = req_last[owner] | (beat_cnt == MAX_BURST-1)`.
  - On an accepted `last`: `last_owner <= owner` and go to `IDLE`. The grant is released, and there is always one arbitration bubble between bursts.
  - If `req_valid[owner]` is low, hold the grant; beats may be non-contiguous.
  - A forced release at `MAX_BURST` sets `rsp_last` on that beat. The requester then re-arbitrates for its remaining beats.
- **Idle operands:** without an accept, `mul_a`/`mul_b` hold their previous value.
- **Tag pipe:** a shift register of depth `1+MUL_LAT`, always shifting. A 0 is inserted when there is no accept.
- **Tag pipe output:** the tail tag drives `rsp_valid = valid ? onehot(owner) : 0` and `rsp_last`.
- **No result backpressure:** a requester must sink a result in the cycle it arrives.
- **No arithmetic in this block:** products are already Q-format-aligned by the bank, and the bank owns rounding and saturation.

## Timing
- **Reset values:**
  - state `IDLE`; `owner=0`; `last_owner=NUM_REQ-1`, so requester 0 has first priority.
  - `beat_cnt=0`; `req_ready=0`; `mul_a=mul_b=0`.
  - all tags invalid; `rsp_valid=0`; `rsp_last=0`; `busy=0`.
- **Request to ready:** `req_valid` high in `IDLE` at cycle t gives `req_ready` high at t+1.
- **Accept to result:** an accept at cycle t gives `mul_a`/`mul_b` valid at t+1 and `rsp_valid` at t+1+`MUL_LAT`.
- **Throughput:** one beat per cycle within a burst.
- **Simultaneous accept-of-last and new requests:** the new requests are evaluated in `IDLE` on the next cycle. The previous owner has lowest priority.
- **Reset mid-burst:** all in-flight tags are discarded and no `rsp_valid` is produced for them. Results still emerging from the bank are ignored.

## Configuration
- **`MUL_SCHED_FIXED_PRIO_EN` defined:** fixed priority; the lowest requester index wins. `last_owner` is unused.
- **Undefined (default):** round robin as described above.

## Test plan
- **Single beat:** reset, then req0 sends a=0x0C0 (1.5) and b=0x100 (2.0) on all lanes with last=1. Expect `req_ready[0]` at cycle 1, and `rsp_valid=3'b001`, `rsp_data` lanes 0x180 (3.0), `rsp_last=1` exactly 1+`MUL_LAT` cycles after accept.
- **Round robin:** req0, req1 and req2 all hold valid with 2-beat bursts. Expect grant order 0,1,2,0, one bubble between bursts, and responses one-hot matching order.
- **Forced release:** req1 streams 20 beats with last never set. Expect release after beat 16 with `rsp_last` on beat 16, then req1 re-granted for the remaining 4 beats if alone.
- **Gaps:** the owner drops valid for 3 cycles mid-burst. Expect the grant held, no tags issued for the gap, and `rsp_valid` gaps mirroring the input gaps.
- **Reset mid-flight:** assert `rst` low one cycle after accepting 2 beats. Expect no `rsp_valid`, `busy=0`, and req0 priority after reset.
- **Fixed-priority build:** with the macro defined, req2 and req0 request continuously. Expect req0 to always win.

Source files
------------

// File: rtl/mul_bank_scheduler.sv
// mul_bank_scheduler
//   Shares one LANES-wide fixed-point multiplier bank between NUM_REQ
//   requesters. The bank is granted in bursts of up to MAX_BURST beats. The
//   winning requester's operands are registered onto mul_a/mul_b. A tag pipe
//   whose depth matches the bank latency routes each product back to the
//   requester that issued it.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   req_valid/req_last    per-requester beat valid / final beat of burst
//   req_a/req_b           flattened operands, requester i at slice i*LANES*WIDTH
//   req_ready             per-requester accept (at most one bit high)
//   mul_a/mul_b           registered operands to the bank
//   mul_result            bank product, MUL_LAT cycles after mul_a/mul_b
//   rsp_valid/rsp_last    one-hot result strobe / result is final beat of burst
//   rsp_data              pass-through of mul_result
//   busy                  grant active or any tag still in flight
//
// Build option
//   MUL_SCHED_FIXED_PRIO_EN : lowest requester index always wins arbitration
//                             (default build is round robin)
module mul_bank_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int LANES     = 32,
    parameter int WIDTH     = 14,
    parameter int MUL_LAT   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*LANES*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*LANES*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [LANES*WIDTH-1:0]           mul_a,
    output logic [LANES*WIDTH-1:0]           mul_b,
    input  logic [LANES*WIDTH-1:0]           mul_result,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic                             rsp_last,
    output logic [LANES*WIDTH-1:0]           rsp_data,
    output logic                             busy
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int VW = LANES * WIDTH;

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic          vld;
        logic [OW-1:0] owner;
        logic          last;
    } tag_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [VW-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    tag_t             tag_q [MUL_LAT+1];
    tag_t             tag_d [MUL_LAT+1];
`ifndef MUL_SCHED_FIXED_PRIO_EN
    logic [OW-1:0]    last_owner_q, last_owner_d;
`endif

    logic [OW-1:0]    win;
    logic             found;
    logic             accept;
    logic             is_last;

    // Arbitration winner among the currently valid requesters.
    always_comb begin
        win   = '0;
        found = 1'b0;
`ifdef MUL_SCHED_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[OW'(i)]) begin
                win   = OW'(i);
                found = 1'b1;
            end
        end
`else
        // Search starts just past the previous owner so it ranks last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[OW'((int'(last_owner_q) + k) % NUM_REQ)]) begin
                win   = OW'((int'(last_owner_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
`endif
    end

    assign accept  = req_valid[owner_q] & req_ready_q[owner_q];
    // A burst also ends when it reaches MAX_BURST beats, even without req_last.
    assign is_last = req_last[owner_q] | (beat_cnt_q == BW'(MAX_BURST - 1));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
`ifndef MUL_SCHED_FIXED_PRIO_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d    = win;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    mul_a_d    = req_a[int'(owner_q) * VW +: VW];
                    mul_b_d    = req_b[int'(owner_q) * VW +: VW];
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (is_last) begin
                        // Returning to IDLE leaves one arbitration bubble between bursts.
`ifndef MUL_SCHED_FIXED_PRIO_EN
                        last_owner_d = owner_q;
`endif
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = '0;
        if (state_d == GRANT) req_ready_d[owner_d] = 1'b1;

        // Tag pipe always shifts; an invalid tag is inserted when no beat is accepted.
        tag_d[0] = accept ? '{vld: 1'b1, owner: owner_q, last: is_last} : '0;
        for (int i = 1; i <= MUL_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            req_ready_q  <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
`ifndef MUL_SCHED_FIXED_PRIO_EN
            last_owner_q <= OW'(NUM_REQ - 1);
`endif
            for (int i = 0; i <= MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            req_ready_q  <= req_ready_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
`ifndef MUL_SCHED_FIXED_PRIO_EN
            last_owner_q <= last_owner_d;
`endif
            for (int i = 0; i <= MUL_LAT; i++) tag_q[i] <= tag_d[i];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_q[MUL_LAT].vld) rsp_valid[tag_q[MUL_LAT].owner] = 1'b1;
        busy = (state_q == GRANT);
        for (int i = 0; i <= MUL_LAT; i++) busy = busy | tag_q[i].vld;
    end

    assign rsp_last  = tag_q[MUL_LAT].vld & tag_q[MUL_LAT].last;
    assign rsp_data  = mul_result;
    assign req_ready = req_ready_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul_bank_scheduler.sv
module tb_mul_bank_scheduler;
    localparam int N     = 3;
    localparam int LANES = 32;
    localparam int W     = 14;
    localparam int LAT   = 1;
    localparam int MB    = 16;
    localparam int FRAC  = 7;
    localparam int VW    = LANES * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0]      req_valid = '0, req_last = '0, req_ready, rsp_valid;
    logic [N*VW-1:0]   req_a = '0, req_b = '0;
    logic [VW-1:0]     mul_a, mul_b, mul_result = '0, rsp_data;
    logic              rsp_last, busy;

    mul_bank_scheduler #(.NUM_REQ(N), .LANES(LANES), .WIDTH(W), .MUL_LAT(LAT), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Lane-wise Q-format product: keep the WIDTH bits above the fraction.
    function automatic logic [VW-1:0] prod(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [2*W-1:0] p;
        logic [VW-1:0]  r;
        for (int l = 0; l < LANES; l++) begin
            p = {{W{1'b0}}, a[l*W +: W]} * {{W{1'b0}}, b[l*W +: W]};
            r[l*W +: W] = p[FRAC +: W];
        end
        return r;
    endfunction

    // Bank stand-in with a single cycle of latency.
    always @(posedge clk) mul_result <= prod(mul_a, mul_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int             due;
        int             own;
        bit             last;
        logic [VW-1:0]  data;
    } rsp_t;

    rsp_t          q[$];
    bit            m_grant;
    int            m_own, m_last, m_cnt;
    int            edge_n = 0;
    bit            acc_now;
    logic [VW-1:0] exp_ma, exp_mb;
    int            acc_beats[N];
    int            grant_log[$];
    logic [N-1:0]  prev_ready = '0;
    int            rsp_cnt, last_at, last_n;

    task automatic model_reset();
        m_grant = 0; m_own = 0; m_last = N - 1; m_cnt = 0; acc_now = 0;
        q.delete();
    endtask

    function automatic int pick();
        int w;
        w = -1;
`ifdef MUL_SCHED_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (req_valid[i]) w = i;
`else
        for (int k = N; k >= 1; k--) if (req_valid[(m_last + k) % N]) w = (m_last + k) % N;
`endif
        return w;
    endfunction

    // Predict what the coming clock edge does with the present inputs.
    task automatic model_edge();
        bit lst;
        acc_now = 0;
        if (!rst) begin
            model_reset();
        end else if (m_grant) begin
            if (req_valid[m_own]) begin
                lst = req_last[m_own] || (m_cnt == MB - 1);
                q.push_back('{due: edge_n + 1 + LAT, own: m_own, last: lst,
                              data: prod(req_a[m_own*VW +: VW], req_b[m_own*VW +: VW])});
                exp_ma = req_a[m_own*VW +: VW];
                exp_mb = req_b[m_own*VW +: VW];
                acc_now = 1;
                m_cnt++;
                acc_beats[m_own]++;
                if (lst) begin m_last = m_own; m_grant = 0; end
            end
        end else if (pick() >= 0) begin
            m_own = pick(); m_grant = 1; m_cnt = 0;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_ready, e_rv;
        bit e_last, e_busy;
        e_ready = m_grant ? N'(1 << m_own) : '0;
        e_busy  = m_grant || (q.size() > 0);
        e_rv = '0; e_last = 0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            e_rv = N'(1 << q[0].own);
            e_last = q[0].last;
            chk("rsp_data", rsp_data, q[0].data);
            void'(q.pop_front());
        end
        chk("req_ready", VW'(req_ready), VW'(e_ready));
        chk("rsp_valid", VW'(rsp_valid), VW'(e_rv));
        chk("rsp_last", VW'(rsp_last), VW'(e_last));
        chk("busy", VW'(busy), VW'(e_busy));
        if (acc_now) begin
            chk("mul_a", mul_a, exp_ma);
            chk("mul_b", mul_b, exp_mb);
        end
        if (req_ready != 0 && prev_ready == 0)
            for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
        prev_ready = req_ready;
        if (rsp_valid != 0) begin
            rsp_cnt++;
            if (rsp_last) begin last_n++; last_at = rsp_cnt; end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        edge_n++;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        req_valid = '0; req_last = '0;
        rst = 1'b0;
        #1;
        model_reset();
        chk("reset rsp_valid", VW'(rsp_valid), '0);
        chk("reset busy", VW'(busy), '0);
        chk("reset req_ready", VW'(req_ready), '0);
        chk("reset mul_a", mul_a, '0);
        repeat (2) step();
        rst = 1'b1;
        prev_ready = '0;
        grant_log.delete();
        rsp_cnt = 0; last_at = 0; last_n = 0;
        for (int i = 0; i < N; i++) acc_beats[i] = 0;
    endtask

    task automatic rand_ops();
        for (int j = 0; j < N * LANES; j++) begin
            req_a[j*W +: W] = W'($urandom);
            req_b[j*W +: W] = W'($urandom);
        end
    endtask

    typedef struct {
        logic [N-1:0] v, l, e_ready, e_rsp;
        logic         e_last;
    } vec_t;

    vec_t tbl[5];
    int   gap_v[12];
    int   n2;

    initial begin
        // Single beat: 1.5 * 2.0 = 3.0 on every lane.
        tbl[0] = '{v: 3'b001, l: 3'b001, e_ready: 3'b001, e_rsp: 3'b000, e_last: 1'b0};
        tbl[1] = '{v: 3'b001, l: 3'b001, e_ready: 3'b000, e_rsp: 3'b000, e_last: 1'b0};
        tbl[2] = '{v: 3'b000, l: 3'b000, e_ready: 3'b000, e_rsp: 3'b001, e_last: 1'b1};
        tbl[3] = '{v: 3'b000, l: 3'b000, e_ready: 3'b000, e_rsp: 3'b000, e_last: 1'b0};
        tbl[4] = '{v: 3'b000, l: 3'b000, e_ready: 3'b000, e_rsp: 3'b000, e_last: 1'b0};
        gap_v = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

        do_reset();
        for (int j = 0; j < LANES; j++) begin
            req_a[j*W +: W] = 14'h0C0;
            req_b[j*W +: W] = 14'h100;
        end
        for (int t = 0; t < 5; t++) begin
            req_valid = tbl[t].v; req_last = tbl[t].l;
            step();
            chk($sformatf("tbl%0d ready", t), VW'(req_ready), VW'(tbl[t].e_ready));
            chk($sformatf("tbl%0d rsp_valid", t), VW'(rsp_valid), VW'(tbl[t].e_rsp));
            chk($sformatf("tbl%0d rsp_last", t), VW'(rsp_last), VW'(tbl[t].e_last));
            if (tbl[t].e_rsp != 0) chk("tbl data 3.0", rsp_data, {LANES{14'h180}});
        end

        // Round robin with 2-beat bursts from everyone.
        do_reset();
        rand_ops();
        for (int t = 0; t < 14; t++) begin
            req_valid = '1;
            for (int i = 0; i < N; i++) req_last[i] = (acc_beats[i] % 2 == 1);
            step();
        end
`ifdef MUL_SCHED_FIXED_PRIO_EN
        for (int g = 0; g < 4; g++) chk($sformatf("fp order%0d", g), VW'(grant_log[g]), '0);
`else
        for (int g = 0; g < 4; g++) chk($sformatf("rr order%0d", g), VW'(grant_log[g]), VW'(g % N));
`endif

        // Forced release: 20 beats from req1 without req_last.
        do_reset();
        for (int t = 0; t < 40 && acc_beats[1] < 20; t++) begin
            rand_ops();
            req_valid = (acc_beats[1] < 20) ? 3'b010 : 3'b000;
            req_last = '0;
            step();
        end
        req_valid = '0;
        repeat (4) step();
        chk("forced rsp count", VW'(rsp_cnt), VW'(20));
        chk("forced last count", VW'(last_n), VW'(1));
        chk("forced last beat", VW'(last_at), VW'(16));
        chk("forced regrants", VW'(grant_log.size()), VW'(2));

        // Grant held across a 3-cycle valid gap.
        do_reset();
        for (int t = 0; t < 12; t++) begin
            rand_ops();
            req_valid = gap_v[t] ? 3'b100 : 3'b000;
            req_last = (acc_beats[2] == 3) ? 3'b100 : 3'b000;
            step();
            if (t >= 3 && t <= 5) chk("gap ready held", VW'(req_ready), VW'(3'b100));
        end
        chk("gap rsp count", VW'(rsp_cnt), VW'(4));

        // Reset while two beats are in flight.
        do_reset();
        req_valid = 3'b001; req_last = '0;
        repeat (3) step();
        chk("pre-reset beats", VW'(acc_beats[0]), VW'(2));
        do_reset();
        chk("post-reset rsp", VW'(rsp_cnt), '0);
        req_valid = 3'b011;
        step();
        chk("post-reset prio req0", VW'(req_ready), VW'(3'b001));
        step();
        chk("post-reset rsp none", VW'(rsp_valid), '0);

        // req0 and req2 compete continuously with single-beat bursts.
        do_reset();
        for (int t = 0; t < 12; t++) begin
            req_valid = 3'b101; req_last = 3'b101;
            step();
        end
        n2 = 0;
        foreach (grant_log[g]) if (grant_log[g] == 2) n2++;
`ifdef MUL_SCHED_FIXED_PRIO_EN
        chk("fixed prio req2 grants", VW'(n2), '0);
`else
        chk("rr req2 grants", VW'(n2), VW'(grant_log.size() / 2));
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            rand_ops();
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                req_last[i]  = ($urandom_range(0, 9) < 3);
            end
            step();
        end
        req_valid = '0;
        repeat (4) step();
        chk("drained", VW'(q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
